// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head output and an occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       txclk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; data is not reset, only the pointers and count are.
  always_ff @(posedge txclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART
// transmitter through its ld_tx_data / tx_data / tx_empty handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   txclk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   tx_en_i,
  input  logic                   tx_empty,
  output logic                   ld_tx_data,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_enable,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  feeder_state_t     state;
  feeder_state_t     state_nxt;
  logic              start;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  // Full is derived from the registered count, so wr_ready has no input path.
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && !fifo_full;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .txclk (txclk),
    .reset (reset),
    .push  (push),
    .pop   (start),
    .din   (wr_data),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Feeder state register.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start pops the head and launches the load strobe.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en_i && !fifo_empty && tx_empty) begin
          start     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!tx_empty) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_empty)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // One-cycle load strobe; tx_data holds the last loaded byte until the next load.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      ld_tx_data <= 1'b0;
      tx_data    <= '0;
    end else begin
      ld_tx_data <= start;
      if (start) tx_data <= fifo_dout;
    end
  end

  // Registered enable forwarded to the UART.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) tx_enable <= 1'b0;
    else        tx_enable <= tx_en_i;
  end

  // Sticky overflow; a new overflow in the clear cycle keeps the flag set.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset)                    overflow <= 1'b0;
    else if (wr_valid && fifo_full) overflow <= 1'b1;
    else if (clr_overflow)          overflow <= 1'b0;
  end

endmodule : uart_tx_feeder

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers transmit bytes in a small synchronous FIFO and feeds them one at a time into the existing UART transmitter, using that transmitter's parallel-load handshake (ld_tx_data / tx_data / tx_empty).
- Sits directly upstream of the UART TX path, in the txclk domain.
- Lets a producer burst up to DEPTH bytes without polling tx_empty.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.
- DATA_W, 8: byte width; fixed to match the UART tx_data width.

Ports:
- txclk  input  1  single clock; the UART transmit clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  producer presents a byte.
- wr_data  input  DATA_W  byte to enqueue.
- wr_ready  output  1  FIFO not full; a write is accepted when wr_valid && wr_ready at the txclk edge.
- tx_en_i  input  1  software enable for feeding and transmitting.
- tx_empty  input  1  from UART; high means its TX holding register is free.
- ld_tx_data  output  1  one-cycle load strobe to the UART.
- tx_data  output  DATA_W  byte to the UART; stable while ld_tx_data is high.
- tx_enable  output  1  registered copy of tx_en_i, driven to the UART.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was attempted while the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset values (reset low, asynchronous): FIFO pointers 0, level=0, wr_ready=1, ld_tx_data=0, tx_data=0, tx_enable=0, overflow=0, FSM=IDLE.
- Reset asserted mid-transfer aborts the feeder immediately; any queued bytes are discarded.
- All outputs are registered; no combinational path from inputs to outputs except wr_ready, which is derived from registered level.

FIFO:
- wr_ready = (level != DEPTH).
- Write when full: the byte is dropped and overflow is set. The same cycle's pop does not make room for it; there is no pass-through.
- Pointers wrap modulo DEPTH.
- level is incremented on a push, decremented on a pop, and unchanged when both occur in the same cycle.
- overflow set and clr_overflow in the same cycle: set wins.

FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE -> LOAD when tx_en_i && level!=0 && tx_empty at the edge.
  - On that edge the head byte is popped into tx_data and ld_tx_data is set to 1.
- LOAD -> WAIT_BUSY unconditionally after one cycle; ld_tx_data returns to 0, so the strobe is exactly 1 cycle wide.
- WAIT_BUSY -> WAIT_DONE when tx_empty==0, i.e. the UART has accepted the byte.
- WAIT_DONE -> IDLE when tx_empty==1.
- tx_data holds its value until the next load.

Timing and corner cases:
- Latency: a write accepted at edge E0 into an idle, empty feeder with tx_empty=1 and tx_en_i=1 gives ld_tx_data high in the cycle following E1.
- Minimum load-to-load spacing is 4 txclk cycles after tx_empty rises again.
- tx_en_i deasserted:
  - No new load starts.
  - A transfer already in progress completes its handshake.
  - tx_enable follows tx_en_i with 1 cycle of delay.
- tx_empty low while in IDLE (UART busy from an external source): the feeder waits; no strobe is issued.
- FIFO empty while the FSM is in IDLE: the feeder stays in IDLE and level stays 0; there is no underflow.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] feeder_state_t {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}
  - localparam UART_DATA_W = 8
- One sub-module, uart_sync_fifo (params DEPTH, DATA_W):
  - Ports: push, pop, din, dout (head, combinational), level, full, empty.
  - Same clock and reset as the parent.
- uart_tx_feeder contains the FSM, the output registers and the overflow logic.

Test Plan:
1. Single byte: after reset, write 0xA5 with tx_en_i=1 and the UART model's tx_empty=1 -> ld_tx_data high for exactly 1 cycle, one cycle after the write edge, with tx_data=0xA5; the received byte checked in loopback is 0xA5.
2. Burst and ordering: write 0x01..0x08 back-to-back (DEPTH=8) -> wr_ready drops after the 8th write and level=8; the UART emits 0x01..0x08 in order with exactly 8 strobes; level returns to 0.
3. Overflow: fill to 8, then write 0xFF while ld is held off (tx_en_i=0) -> 0xFF is dropped and overflow=1; pulse clr_overflow -> overflow=0; the contents are unchanged.
4. Enable gating: queue 0x3C with tx_en_i=0 -> no ld_tx_data and tx_enable=0; raise tx_en_i -> tx_enable=1 after 1 cycle and the load follows.
5. Busy UART: hold tx_empty=0 in IDLE with level=2 -> no strobe; release tx_empty -> 2 sequential loads, each waiting for tx_empty to fall and then rise.
6. Reset mid-operation: drive reset low during WAIT_BUSY with level=3 -> immediately level=0, ld_tx_data=0, tx_data=0, FSM=IDLE; after release, no stale byte is loaded.
